ysyx_22040931_dmem_resp: RTL and testbench

Data-memory responder that sits on the far side of the core's MEM-stage memory port. It accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs a byte-masked access to an internal doubleword-organised RAM, and returns read data plus an error flag over a second valid/ready handshake. It replaces the simulation-only memory model behind the pipeline, so that stall and back-pressure paths in the core can be exercised.

---
 rtl/ysyx_22040931_dmem_resp_pkg.sv | 47 ++++
 rtl/ysyx_22040931_dmem_ram.sv | 27 ++
 rtl/ysyx_22040931_dmem_resp.sv | 130 +++++++++++++
 tb/tb_ysyx_22040931_dmem_resp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040931_dmem_resp_pkg.sv
// Shared bus/size/state definitions and access helpers for the data-memory responder.
// Macros mirror the core's defines; the package wraps them as types and functions.
`ifndef YSYX_22040931_DMEM_DEFINES
`define YSYX_22040931_DMEM_DEFINES
`define ysyx_22040931_DATA_BUS 63:0
`define ysyx_22040931_MEM_BUS  63:0
`define ysyx_22040931_SIZE_B   2'b00
`define ysyx_22040931_SIZE_H   2'b01
`define ysyx_22040931_SIZE_W   2'b10
`define ysyx_22040931_SIZE_D   2'b11
`define ysyx_22040931_DMEM_BASE 64'h0000_0000_8000_0000
`define ysyx_22040931_ST_IDLE  2'd0
`define ysyx_22040931_ST_WAIT  2'd1
`define ysyx_22040931_ST_RESP  2'd2
`endif

package ysyx_22040931_dmem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `ysyx_22040931_ST_IDLE,
        ST_WAIT = `ysyx_22040931_ST_WAIT,
        ST_RESP = `ysyx_22040931_ST_RESP
    } state_t;

    localparam logic [1:0] SIZE_B = `ysyx_22040931_SIZE_B;
    localparam logic [1:0] SIZE_H = `ysyx_22040931_SIZE_H;
    localparam logic [1:0] SIZE_W = `ysyx_22040931_SIZE_W;
    localparam logic [1:0] SIZE_D = `ysyx_22040931_SIZE_D;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SIZE_H:  return off[0];
            SIZE_W:  return |off[1:0];
            SIZE_D:  return |off;
            default: return 1'b0;
        endcase
    endfunction

    // Lane mask of an aligned access: (2^bytes - 1) shifted to the byte offset.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] m;
        m = (16'd1 << (4'd1 << size)) - 16'd1;
        m = m << off;
        return m[7:0];
    endfunction

endpackage

// File: rtl/ysyx_22040931_dmem_ram.sv
// Single-port DEPTH x 64 RAM: byte-masked synchronous write, combinational read.
// The responder registers read data itself, so the array needs no output register.
module ysyx_22040931_dmem_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    mask,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (mask[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_22040931_dmem_resp.sv
// MEM-stage data-memory responder: one request at a time, LATENCY wait states, then a held response.
// Response appears LATENCY+1 cycles after accept; req_ready stays low until the response is taken.
module ysyx_22040931_dmem_resp
    import ysyx_22040931_dmem_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = `ysyx_22040931_DMEM_BASE,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  LAT      = 4'(LATENCY);
    localparam bit          NO_WAIT  = (LATENCY == 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    logic          in_idle;
    logic          take;
    logic          fire;
    logic          a_wr;
    logic [1:0]    a_size;
    logic [63:0]   a_addr;
    logic [63:0]   a_wdata;
    logic [63:0]   a_off;
    logic          a_err;
    logic [63:0]   a_rdata;
    logic [63:0]   ram_rdata;
    logic [AW-1:0] idx;
    logic          ram_we;

    assign in_idle = (state == ST_IDLE);
    assign take    = in_idle && req_valid && req_ready;
    // The access edge is either the accept edge (no wait states) or the last WAIT cycle.
    assign fire    = (take && NO_WAIT) || ((state == ST_WAIT) && (cnt == 4'd1));

    // With no wait states the access uses the live request, otherwise the latched copy.
    assign a_wr    = in_idle ? req_wr    : wr_q;
    assign a_size  = in_idle ? req_size  : size_q;
    assign a_addr  = in_idle ? req_addr  : addr_q;
    assign a_wdata = in_idle ? req_wdata : wdata_q;

    // Below-base addresses wrap to a huge offset; the range compare rejects them before indexing matters.
    assign a_off   = a_addr - BASE_ADDR;
    assign idx     = AW'(a_off >> 3);
    assign a_err   = misaligned(a_size, a_addr[2:0]) || (a_addr < BASE_ADDR) || (a_addr >= END_ADDR);
    assign ram_we  = fire && reset && a_wr && !a_err;
    assign a_rdata = (a_wr || a_err) ? 64'd0 : ram_rdata;

    ysyx_22040931_dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .idx   (idx),
        .mask  (byte_mask(a_size, a_addr[2:0])),
        .wdata (a_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (take) begin
                        req_ready <= 1'b0;
                        wr_q      <= req_wr;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt       <= LAT;
                        if (NO_WAIT) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= a_rdata;
                            rsp_err   <= a_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (fire) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= a_rdata;
                        rsp_err   <= a_err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_dmem_resp.sv
// Directed scoreboard bench over three builds of the responder (LATENCY 1, 0 and 15).
module tb_ysyx_22040931_dmem_resp;

    localparam int NI = 3;
    localparam int LATS [NI] = '{1, 0, 15};

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_wr    [NI];
    logic [1:0]  req_size  [NI];
    logic [63:0] req_addr  [NI];
    logic [63:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [63:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ysyx_22040931_dmem_resp #(
            .DEPTH     (1024),
            .BASE_ADDR (64'h8000_0000),
            .LATENCY   (LATS[g])
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wr    (req_wr[g]),
            .req_size  (req_size[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request on instance i, then check latency, response and the return to IDLE.
    task automatic txn(input int i, input logic wr, input logic [1:0] size,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input logic exp_err, input int stall);
        exp_t e;
        int   n;
        logic seen;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_wait", 64'(req_ready[i]), 64'd1);
        if (req_ready[i] !== 1'b1) begin
            void'(sb.pop_front());
            return;
        end
        rsp_ready[i] = (stall == 0);
        req_valid[i] = 1'b1;
        req_wr[i]    = wr;
        req_size[i]  = size;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clock);
            n++;
            req_valid[i] = 1'b0;
            seen = (rsp_valid[i] === 1'b1);
        end
        e = sb.pop_front();
        chk("rsp_latency", 64'(n), 64'(LATS[i] + 1));
        chk("rsp_valid", 64'(rsp_valid[i]), 64'd1);
        chk("rsp_rdata", rsp_rdata[i], e.rdata);
        chk("rsp_err", 64'(rsp_err[i]), 64'(e.err));
        for (int k = 0; k < stall; k++) begin
            @(negedge clock);
            chk("stall_valid", 64'(rsp_valid[i]), 64'd1);
            chk("stall_rdata", rsp_rdata[i], e.rdata);
            chk("stall_err", 64'(rsp_err[i]), 64'(e.err));
            chk("stall_req_ready", 64'(req_ready[i]), 64'd0);
        end
        rsp_ready[i] = 1'b1;
        @(negedge clock);
        chk("rsp_done", 64'(rsp_valid[i]), 64'd0);
        chk("req_ready_back", 64'(req_ready[i]), 64'd1);
    endtask

    initial begin
        logic seen_any;
        int   n;
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 1'b0;
            req_wr[i]    = 1'b0;
            req_size[i]  = 2'b00;
            req_addr[i]  = 64'd0;
            req_wdata[i] = 64'd0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < NI; i++) begin
            chk("rst_req_ready", 64'(req_ready[i]), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
            chk("rst_rsp_rdata", rsp_rdata[i], 64'd0);
            chk("rst_rsp_err", 64'(rsp_err[i]), 64'd0);
        end
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < NI; i++) chk("first_req_ready", 64'(req_ready[i]), 64'd1);

        // LATENCY=1 build: functional accesses, errors and back-pressure.
        txn(0, 1'b1, 2'b11, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 0);
        txn(0, 1'b0, 2'b11, 64'h8000_0008, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 0);
        txn(0, 1'b1, 2'b00, 64'h8000_000C, 64'h0000_00AB_0000_0000, 64'd0, 1'b0, 0);
        txn(0, 1'b0, 2'b11, 64'h8000_0008, 64'd0, 64'h1122_33AB_5566_7788, 1'b0, 0);
        txn(0, 1'b1, 2'b11, 64'h8000_0000, 64'hCAFE_F00D_DEAD_BEEF, 64'd0, 1'b0, 0);
        txn(0, 1'b1, 2'b10, 64'h8000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
        txn(0, 1'b0, 2'b11, 64'h8000_0000, 64'd0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 0);
        txn(0, 1'b0, 2'b11, 64'h7FFF_FFF8, 64'd0, 64'd0, 1'b1, 0);
        txn(0, 1'b0, 2'b11, 64'h8000_2000, 64'd0, 64'd0, 1'b1, 0);
        txn(0, 1'b0, 2'b11, 64'h0000_0000, 64'd0, 64'd0, 1'b1, 0);
        txn(0, 1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1, 0);
        txn(0, 1'b1, 2'b01, 64'h8000_0006, 64'h1234_0000_0000_0000, 64'd0, 1'b0, 0);
        txn(0, 1'b0, 2'b10, 64'h8000_0004, 64'd0, 64'h1234_F00D_DEAD_BEEF, 1'b0, 0);
        txn(0, 1'b1, 2'b11, 64'h8000_1FF8, 64'h0BAD_C0DE_0BAD_C0DE, 64'd0, 1'b0, 0);
        txn(0, 1'b0, 2'b11, 64'h8000_1FF8, 64'd0, 64'h0BAD_C0DE_0BAD_C0DE, 1'b0, 5);
        txn(0, 1'b1, 2'b01, 64'h8000_0001, 64'd0, 64'd0, 1'b1, 3);

        // LATENCY=0 and LATENCY=15 builds.
        txn(1, 1'b1, 2'b11, 64'h8000_0010, 64'hA5A5_5A5A_0123_4567, 64'd0, 1'b0, 0);
        txn(1, 1'b0, 2'b11, 64'h8000_0010, 64'd0, 64'hA5A5_5A5A_0123_4567, 1'b0, 0);
        txn(2, 1'b1, 2'b11, 64'h8000_0018, 64'hFEDC_BA98_7654_3210, 64'd0, 1'b0, 0);
        txn(2, 1'b0, 2'b11, 64'h8000_0018, 64'd0, 64'hFEDC_BA98_7654_3210, 1'b0, 0);

        // Reset in the middle of a LATENCY=15 load drops it without a response.
        req_valid[2] = 1'b1;
        req_wr[2]    = 1'b0;
        req_size[2]  = 2'b11;
        req_addr[2]  = 64'h8000_0018;
        @(negedge clock);
        req_valid[2] = 1'b0;
        repeat (4) @(negedge clock);
        chk("mid_wait_req_ready", 64'(req_ready[2]), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid_rst_rsp_valid", 64'(rsp_valid[2]), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_req_ready", 64'(req_ready[2]), 64'd1);
        seen_any = 1'b0;
        for (n = 0; n < 30; n++) begin
            @(negedge clock);
            if (rsp_valid[2] === 1'b1) seen_any = 1'b1;
        end
        chk("no_orphan_rsp", 64'(seen_any), 64'd0);
        txn(2, 1'b0, 2'b11, 64'h8000_0018, 64'd0, 64'hFEDC_BA98_7654_3210, 1'b0, 0);
        txn(0, 1'b0, 2'b11, 64'h8000_0008, 64'd0, 64'h1122_33AB_5566_7788, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
